imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Instruction memory for polirv, plus a byte-stream boot loader.
//  After reset it holds the core in reset and accepts a program as a byte stream:
//  a 2-byte little-endian word count, then that many 32-bit words, little-endian.
//  It then releases core_rst_n and serves i_mem_addr -> i_mem_data combinationally.
//  Sits directly upstream of polirv and drives its rst_n and i_mem_data.
// PARAMETERS
//  i_addr_bits  6  byte-address width of the instruction port; depth = 2**(i_addr_bits-2) words
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous reset, active low
//  ld_valid     in   1   loader byte valid
//  ld_byte      in   8   loader byte
//  ld_ready     out  1   loader can accept a byte
//  reload       in   1   in RUN: restart the load sequence
//  core_rst_n   out  1   reset to polirv, active low, registered
//  done         out  1   program loaded, core running
//  err          out  1   sticky: word count exceeded depth
//  i_mem_addr   in   i_addr_bits  byte address from core
//  i_mem_data   out  32  instruction at word i_mem_addr[i_addr_bits-1:2]; addr[1:0] ignored
// BEHAVIOUR
//  - Transfer happens on a rising edge with ld_valid && ld_ready. ld_byte is sampled only then.
//  - Reset values: state=HDR0, core_rst_n=0, done=0, err=0, counters=0. Memory array is NOT reset.
//  - ld_ready = 1 in HDR0, HDR1 and DATA; 0 in RUN. It is combinational from state only.
//  - FSM:
//    - HDR0: byte -> cnt[7:0]; go to HDR1.
//    - HDR1: byte -> cnt[15:8]. If the full count == 0, go to RUN; else go to DATA with widx=0, bidx=0.
//    - DATA: byte -> shift[8*bidx +: 8]; bidx++.
//      - On bidx==3: write the assembled word to mem[widx] on the same edge, if widx < depth.
//        If widx >= depth, do not write and set err=1.
//      - Then widx++ and bidx=0. When widx+1 == cnt, go to RUN.
//    - RUN: core_rst_n=1 and done=1, both registered; the first RUN cycle is the edge after the final byte.
//      reload=1 -> HDR0 on the next edge, with core_rst_n=0, done=0, err=0.
//  - reload is ignored outside RUN.
//  - Count width is 16 bits; widx is 16 bits and does not wrap within a load.
//    Excess words are consumed but discarded (err set).
//  - i_mem_data = mem[i_mem_addr[i_addr_bits-1:2]], combinational in all states.
//    During a write edge, the read returns the old word until after the edge.
//  - Reset asserted mid-load: immediate return to HDR0, core_rst_n=0. Partially loaded words stay in memory.
//  - A partial word (load aborted by reset) is never written.
// STRUCTURE
//  - Shared include polirv_defs.vh: loader state encoding (HDR0=0, HDR1=1, DATA=2, RUN=3)
//    and the LD_CNT_W=16 constant.
//  - Sub-module imem_ram (i_addr_bits): word array, synchronous write (we, waddr, wdata),
//    combinational read. imem_loader holds the FSM, counters and byte assembly.
// TESTING
//  1. Reset, then stream 02 00 | 13 00 00 00 | 93 00 10 00
//     -> mem[0]=0x00000013, mem[1]=0x00100093; core_rst_n=1 and done=1 on the edge after the last byte;
//        i_mem_addr=4 reads 0x00100093.
//  2. Stream 00 00 -> RUN directly after the second byte; err=0; ld_ready=0 in RUN.
//  3. i_addr_bits=6, count 0x0011 (17 words), 68 data bytes
//     -> mem[0..15] written, 17th word discarded, err=1, done=1.
//  4. ld_valid toggled 1-0-1 with bubbles and ld_byte changing while ld_valid=0 -> same memory image as test 1.
//  5. Assert rst_n low after 6 data bytes, then reload the program of test 1
//     -> correct image; core_rst_n stays 0 throughout the reload.
//  6. In RUN, pulse reload, stream 01 00 | EF BE AD DE
//     -> core_rst_n drops the next cycle, mem[0]=0xDEADBEEF, mem[1] unchanged, done=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the polirv instruction memory and boot loader.
// Loader state encoding, count width and word assembly helper.
package imem_loader_pkg;

    localparam int LD_CNT_W = 16;

    typedef enum logic [1:0] {
        HDR0 = 2'd0,
        HDR1 = 2'd1,
        DATA = 2'd2,
        RUN  = 2'd3
    } ld_state_t;

    // Little-endian word: first three bytes held, last byte arrives live
    function automatic logic [31:0] pack_word(
        input logic [23:0] lo,
        input logic [7:0]  hi
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction word array for polirv.
// Synchronous write port, combinational read port, no reset.
module imem_ram #(
    parameter int i_addr_bits = 6
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [i_addr_bits-3:0] waddr,
    input  logic [31:0]            wdata,
    input  logic [i_addr_bits-3:0] raddr,
    output logic [31:0]            rdata
);

    localparam int DEPTH = 2 ** (i_addr_bits - 2);

    logic [31:0] mem [DEPTH];

    // Write on the clock edge; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is combinational so the old word is seen until the write edge
    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader and instruction memory sitting in front of polirv.
// Takes a byte stream (count, then words) while holding the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int i_addr_bits = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld_valid,
    input  logic [7:0]             ld_byte,
    output logic                   ld_ready,
    input  logic                   reload,
    output logic                   core_rst_n,
    output logic                   done,
    output logic                   err,
    input  logic [i_addr_bits-1:0] i_mem_addr,
    output logic [31:0]            i_mem_data
);

    localparam int WA    = i_addr_bits - 2;
    localparam int DEPTH = 2 ** WA;

    ld_state_t             state_q;
    ld_state_t             state_d;

    logic [LD_CNT_W-1:0]   cnt;
    logic [LD_CNT_W-1:0]   widx;
    logic [LD_CNT_W-1:0]   widx_inc;
    logic [1:0]            bidx;
    logic [23:0]           shift;

    logic                  xfer;
    logic                  last_byte;
    logic                  in_range;
    logic                  last_word;
    logic [LD_CNT_W-1:0]   full_cnt;

    logic                  we;
    logic [WA-1:0]         waddr;
    logic [31:0]           wdata;

    logic                  unused_addr_lsb;

    assign xfer      = ld_valid && ld_ready;
    assign last_byte = (bidx == 2'd3);
    assign widx_inc  = widx + 16'd1;
    assign in_range  = (widx < 16'(DEPTH));
    assign last_word = (widx_inc == cnt);
    assign full_cnt  = {ld_byte, cnt[7:0]};

    assign unused_addr_lsb = ^i_mem_addr[1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: header, data words, then run until reload
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HDR0: begin
                if (xfer) begin
                    state_d = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    state_d = (full_cnt == '0) ? RUN : DATA;
                end
            end
            DATA: begin
                if (xfer && last_byte && last_word) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_d = HDR0;
                end
            end
            default: state_d = HDR0;
        endcase
    end

    // Outputs: byte accept and RAM write strobe
    always_comb begin
        ld_ready = (state_q != RUN);
        we       = 1'b0;
        waddr    = widx[WA-1:0];
        wdata    = pack_word(shift, ld_byte);
        if (state_q == DATA && xfer && last_byte && in_range) begin
            we = 1'b1;
        end
    end

    // Header count, word/byte indices and partial word assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            widx  <= '0;
            bidx  <= '0;
            shift <= '0;
        end else if (xfer) begin
            unique case (state_q)
                HDR0: begin
                    cnt[7:0] <= ld_byte;
                end
                HDR1: begin
                    cnt[15:8] <= ld_byte;
                    widx      <= '0;
                    bidx      <= '0;
                end
                DATA: begin
                    unique case (bidx)
                        2'd0: shift[7:0]   <= ld_byte;
                        2'd1: shift[15:8]  <= ld_byte;
                        2'd2: shift[23:16] <= ld_byte;
                        2'd3: widx         <= widx_inc;
                        default: ;
                    endcase
                    bidx <= bidx + 2'd1;
                end
                RUN: ;
                default: ;
            endcase
        end
    end

    // Core reset and done follow the registered RUN state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rst_n <= 1'b0;
            done       <= 1'b0;
        end else begin
            core_rst_n <= (state_d == RUN);
            done       <= (state_d == RUN);
        end
    end

    // Sticky overflow flag, cleared only by reset or reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state_q == RUN && reload) begin
            err <= 1'b0;
        end else if (state_q == DATA && xfer && last_byte && !in_range) begin
            err <= 1'b1;
        end
    end

    imem_ram #(
        .i_addr_bits(i_addr_bits)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (i_mem_addr[i_addr_bits-1:2]),
        .rdata (i_mem_data)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for the polirv boot loader and instruction memory.
// Each task streams a program and checks flags and memory image.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = 8'h00;
    logic        ld_ready;
    logic        reload = 1'b0;
    logic        core_rst_n;
    logic        done;
    logic        err;
    logic [5:0]  i_mem_addr = 6'd0;
    logic [31:0] i_mem_data;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] prog1 [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                               8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    imem_loader #(.i_addr_bits(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_ready   (ld_ready),
        .reload     (reload),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err),
        .i_mem_addr (i_mem_addr),
        .i_mem_data (i_mem_data)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        ld_valid = 1'b0;
        reload   = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({core_rst_n, done, err, ld_ready} !== 4'b0001)
            $display("FAIL reset_flags: got %b want 0001",
                     {core_rst_n, done, err, ld_ready});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if ({core_rst_n, done, ld_ready} !== 3'b001)
            $display("FAIL reset_release: got %b want 001",
                     {core_rst_n, done, ld_ready});
        else n_pass++;
    endtask

    task automatic test_basic();
        apply_reset();
        for (int i = 0; i < 9; i++) send(prog1[i]);
        n_total++;
        if ({core_rst_n, done} !== 2'b00)
            $display("FAIL basic_pre_last: got %b want 00", {core_rst_n, done});
        else n_pass++;
        send(prog1[9]);
        n_total++;
        if ({core_rst_n, done, err, ld_ready} !== 4'b1100)
            $display("FAIL basic_run: got %b want 1100",
                     {core_rst_n, done, err, ld_ready});
        else n_pass++;
        idle();
        i_mem_addr = 6'd0;
        #1;
        n_total++;
        if (i_mem_data !== 32'h0000_0013)
            $display("FAIL basic_mem0: got %h want 00000013", i_mem_data);
        else n_pass++;
        i_mem_addr = 6'd4;
        #1;
        n_total++;
        if (i_mem_data !== 32'h0010_0093)
            $display("FAIL basic_mem1: got %h want 00100093", i_mem_data);
        else n_pass++;
        i_mem_addr = 6'd7;
        #1;
        n_total++;
        if (i_mem_data !== 32'h0010_0093)
            $display("FAIL basic_addr_lsb: got %h want 00100093", i_mem_data);
        else n_pass++;
    endtask

    task automatic test_zero_count();
        apply_reset();
        send(8'h00);
        n_total++;
        if ({done, ld_ready} !== 2'b01)
            $display("FAIL zero_hdr1: got %b want 01", {done, ld_ready});
        else n_pass++;
        send(8'h00);
        n_total++;
        if ({core_rst_n, done, err, ld_ready} !== 4'b1100)
            $display("FAIL zero_run: got %b want 1100",
                     {core_rst_n, done, err, ld_ready});
        else n_pass++;
        idle();
        i_mem_addr = 6'd0;
        #1;
        n_total++;
        if (i_mem_data !== 32'h0000_0013)
            $display("FAIL zero_mem_kept: got %h want 00000013", i_mem_data);
        else n_pass++;
    endtask

    task automatic test_overflow();
        apply_reset();
        send(8'h11);
        send(8'h00);
        for (int w = 0; w < 17; w++) begin
            if (w == 16) begin
                send(8'h16); send(8'h00); send(8'hD0); send(8'hBA);
            end else begin
                send(8'(w)); send(8'h00); send(8'h00); send(8'h10);
            end
            if (w == 15) begin
                n_total++;
                if ({err, done} !== 2'b00)
                    $display("FAIL ovf_w15: got %b want 00", {err, done});
                else n_pass++;
            end
        end
        n_total++;
        if ({err, done, core_rst_n} !== 3'b111)
            $display("FAIL ovf_end: got %b want 111", {err, done, core_rst_n});
        else n_pass++;
        idle();
        i_mem_addr = 6'd0;
        #1;
        n_total++;
        if (i_mem_data !== 32'h1000_0000)
            $display("FAIL ovf_mem0: got %h want 10000000", i_mem_data);
        else n_pass++;
        i_mem_addr = 6'd60;
        #1;
        n_total++;
        if (i_mem_data !== 32'h1000_000F)
            $display("FAIL ovf_mem15: got %h want 1000000f", i_mem_data);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (err !== 1'b1)
            $display("FAIL ovf_sticky: got %b want 1", err);
        else n_pass++;
        reload = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if ({err, done, core_rst_n, ld_ready} !== 4'b0001)
            $display("FAIL ovf_reload_clr: got %b want 0001",
                     {err, done, core_rst_n, ld_ready});
        else n_pass++;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_bubbles();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            send(prog1[i]);
            @(negedge clk);
            ld_valid = 1'b0;
            ld_byte  = 8'hF0 ^ 8'(i);
            @(posedge clk);
            #1;
            if (i == 4) begin
                n_total++;
                if ({ld_ready, done} !== 2'b10)
                    $display("FAIL bub_mid: got %b want 10", {ld_ready, done});
                else n_pass++;
            end
        end
        n_total++;
        if ({core_rst_n, done} !== 2'b11)
            $display("FAIL bub_run: got %b want 11", {core_rst_n, done});
        else n_pass++;
        i_mem_addr = 6'd0;
        #1;
        n_total++;
        if (i_mem_data !== 32'h0000_0013)
            $display("FAIL bub_mem0: got %h want 00000013", i_mem_data);
        else n_pass++;
        i_mem_addr = 6'd4;
        #1;
        n_total++;
        if (i_mem_data !== 32'h0010_0093)
            $display("FAIL bub_mem1: got %h want 00100093", i_mem_data);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        apply_reset();
        send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'hAA); send(8'hBB);
        ld_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({core_rst_n, done, ld_ready} !== 3'b001)
            $display("FAIL mid_async: got %b want 001",
                     {core_rst_n, done, ld_ready});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i_mem_addr = 6'd0;
        #1;
        n_total++;
        if (i_mem_data !== 32'h4433_2211)
            $display("FAIL mid_mem0: got %h want 44332211", i_mem_data);
        else n_pass++;
        i_mem_addr = 6'd4;
        #1;
        n_total++;
        if (i_mem_data !== 32'h0010_0093)
            $display("FAIL mid_partial: got %h want 00100093", i_mem_data);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            send(prog1[i]);
            n_total++;
            if (core_rst_n !== 1'b0)
                $display("FAIL mid_hold_%0d: got %b want 0", i, core_rst_n);
            else n_pass++;
        end
        send(prog1[9]);
        idle();
        i_mem_addr = 6'd0;
        #1;
        n_total++;
        if ({core_rst_n, i_mem_data} !== {1'b1, 32'h0000_0013})
            $display("FAIL mid_reload: got %b/%h want 1/00000013",
                     core_rst_n, i_mem_data);
        else n_pass++;
    endtask

    task automatic test_reload();
        @(negedge clk);
        reload = 1'b1;
        #1;
        n_total++;
        if (core_rst_n !== 1'b1)
            $display("FAIL rl_registered: got %b want 1", core_rst_n);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({core_rst_n, done, ld_ready} !== 3'b001)
            $display("FAIL rl_drop: got %b want 001",
                     {core_rst_n, done, ld_ready});
        else n_pass++;
        @(negedge clk);
        reload = 1'b0;
        send(8'h01);
        send(8'h00);
        reload = 1'b1;
        send(8'hEF);
        reload = 1'b0;
        n_total++;
        if ({done, ld_ready} !== 2'b01)
            $display("FAIL rl_ignored: got %b want 01", {done, ld_ready});
        else n_pass++;
        send(8'hBE); send(8'hAD); send(8'hDE);
        n_total++;
        if ({core_rst_n, done} !== 2'b11)
            $display("FAIL rl_run: got %b want 11", {core_rst_n, done});
        else n_pass++;
        idle();
        i_mem_addr = 6'd0;
        #1;
        n_total++;
        if (i_mem_data !== 32'hDEAD_BEEF)
            $display("FAIL rl_mem0: got %h want deadbeef", i_mem_data);
        else n_pass++;
        i_mem_addr = 6'd4;
        #1;
        n_total++;
        if (i_mem_data !== 32'h0010_0093)
            $display("FAIL rl_mem1: got %h want 00100093", i_mem_data);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_overflow();
        test_bubbles();
        test_reset_midload();
        test_reload();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
